// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants, per-level parameters and the secret-vector scheduler types.
package dilithium_pkg;
  localparam int unsigned Q       = 8380417;
  localparam int unsigned N       = 256;
  localparam int unsigned COEFF_W = 23;

  localparam logic [3:0] K_LVL2 = 4'd4, L_LVL2 = 4'd4;
  localparam logic [3:0] K_LVL3 = 4'd6, L_LVL3 = 4'd5;
  localparam logic [3:0] K_LVL5 = 4'd8, L_LVL5 = 4'd7;
  localparam logic [2:0] ETA_LVL2 = 3'd2, ETA_LVL3 = 3'd4, ETA_LVL5 = 3'd2;

  // Write-path latency from coefficient strobe to RAM write
  localparam int WR_STAGES = 1;

  typedef struct packed {
    logic [3:0] k;
    logic [3:0] l;
    logic [2:0] eta;
    logic       legal;
  } lvl_cfg_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_COLLECT, S_WAIT_DONE, S_FINISH
  } sched_state_t;

  function automatic lvl_cfg_t decode_level(input logic [2:0] lvl);
    lvl_cfg_t c;
    c = '0;
    case (lvl)
      3'd2: c = '{k: K_LVL2, l: L_LVL2, eta: ETA_LVL2, legal: 1'b1};
      3'd3: c = '{k: K_LVL3, l: L_LVL3, eta: ETA_LVL3, legal: 1'b1};
      3'd5: c = '{k: K_LVL5, l: L_LVL5, eta: ETA_LVL5, legal: 1'b1};
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/eta_to_modq.sv
// Maps a raw sampled value x in [0, 2*eta] to the coefficient (eta - x) mod q.
module eta_to_modq #(
  parameter int unsigned Q = dilithium_pkg::Q
) (
  input  logic [3:0]  x,
  input  logic [2:0]  eta,
  output logic [22:0] coeff
);
  localparam logic [22:0] QW = Q[22:0];

  logic [22:0] x_w, eta_w;
  assign x_w   = {19'd0, x};
  assign eta_w = {20'd0, eta};

  always_comb begin
    if (x_w <= eta_w) coeff = eta_w - x_w;
    else              coeff = QW - (x_w - eta_w);
  end
endmodule

// File: rtl/keygen_s_sched.sv
// Walks every s1/s2 polynomial: launches the sampler per row, maps raw samples
// to coefficients mod q and writes them into the secret-polynomial RAM.
module keygen_s_sched
  import dilithium_pkg::*;
#(
  parameter int unsigned Q      = dilithium_pkg::Q,
  parameter int          ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_security_level,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_smp_start,
  output logic [2:0]        o_smp_level,
  output logic [15:0]       o_smp_row,
  input  logic              i_smp_coeff_valid,
  input  logic [3:0]        i_smp_coeff_data,
  input  logic              i_smp_done,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [22:0]       o_wr_data
);
  sched_state_t state_q, state_d;
  lvl_cfg_t     cfg_in;
  logic [2:0]   level_q, eta_q;
  logic [3:0]   poly_q, last_poly_q;
  logic [7:0]   coeff_q;
  logic         err_q;
  logic [22:0]  coeff_map;
  logic [WR_STAGES:0] vld_pipe;

  assign cfg_in = decode_level(i_security_level);

  logic accept, wr_fire, stray, last_coeff;
  assign accept     = (state_q == S_IDLE) && i_start;
  assign wr_fire    = (state_q == S_COLLECT) && i_smp_coeff_valid;
  // Strobes outside COLLECT are dropped but remembered as a protocol error
  assign stray      = i_smp_coeff_valid && ((state_q == S_LAUNCH) || (state_q == S_WAIT_DONE));
  assign last_coeff = (coeff_q == 8'(N - 1));

  eta_to_modq #(.Q(Q)) u_map (.x(i_smp_coeff_data), .eta(eta_q), .coeff(coeff_map));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (i_start) state_d = cfg_in.legal ? S_LAUNCH : S_FINISH;
      S_LAUNCH:    state_d = S_COLLECT;
      S_COLLECT:   if (i_smp_coeff_valid && last_coeff) state_d = S_WAIT_DONE;
      // Done is only trusted here, which hides the previous row's stale level
      S_WAIT_DONE: if (i_smp_done) state_d = (poly_q == last_poly_q) ? S_FINISH : S_LAUNCH;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state_q == S_LAUNCH) || (state_q == S_COLLECT) || (state_q == S_WAIT_DONE);
    o_smp_start = (state_q == S_LAUNCH);
    o_done      = (state_q == S_FINISH);
    o_err       = (state_q == S_FINISH) && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      eta_q       <= '0;
      last_poly_q <= '0;
      poly_q      <= '0;
      coeff_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        level_q     <= i_security_level;
        eta_q       <= cfg_in.eta;
        last_poly_q <= cfg_in.l + cfg_in.k - 4'd1;
        poly_q      <= '0;
        err_q       <= ~cfg_in.legal;
      end
      if (state_q == S_LAUNCH) coeff_q <= '0;
      if (wr_fire)             coeff_q <= coeff_q + 8'd1;
      if ((state_q == S_WAIT_DONE) && i_smp_done && (poly_q != last_poly_q))
        poly_q <= poly_q + 4'd1;
      if (stray) err_q <= 1'b1;
    end
  end

  assign vld_pipe[0] = wr_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[WR_STAGES:1] <= '0;
      o_wr_addr             <= '0;
      o_wr_data             <= '0;
    end else begin
      vld_pipe[WR_STAGES:1] <= vld_pipe[WR_STAGES-1:0];
      if (wr_fire) begin
        o_wr_addr <= ADDR_W'({poly_q, coeff_q});
        o_wr_data <= coeff_map;
      end
    end
  end

  assign o_wr_en     = vld_pipe[WR_STAGES];
  assign o_smp_level = level_q;
  assign o_smp_row   = {12'd0, poly_q};
endmodule

// File: tb/tb_keygen_s_sched.sv
// Randomized bench: behavioural sampler feeds the scheduler, a scoreboard checks every RAM write.
module tb_keygen_s_sched;
  localparam int Q = 8380417;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_security_level = 3'd0;
  logic        o_busy, o_done, o_err, o_smp_start;
  logic [2:0]  o_smp_level;
  logic [15:0] o_smp_row;
  logic        i_smp_coeff_valid = 1'b0;
  logic [3:0]  i_smp_coeff_data = 4'd0;
  logic        i_smp_done = 1'b0;
  logic        o_wr_en;
  logic [11:0] o_wr_addr;
  logic [22:0] o_wr_data;

  always #5 clk = ~clk;

  keygen_s_sched #(.Q(Q), .ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_security_level(i_security_level),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_smp_start(o_smp_start),
    .o_smp_level(o_smp_level), .o_smp_row(o_smp_row),
    .i_smp_coeff_valid(i_smp_coeff_valid), .i_smp_coeff_data(i_smp_coeff_data),
    .i_smp_done(i_smp_done), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
  );

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int checks = 0, passes = 0;
  int wr_cnt = 0, start_cnt = 0, done_cnt = 0, exp_row = 0, exp_level = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic void lvl_params(input int lvl, output int l, output int k,
                                     output int eta, output bit legal);
    legal = 1; l = 0; k = 0; eta = 0;
    case (lvl)
      2: begin l = 4; k = 4; eta = 2; end
      3: begin l = 5; k = 6; eta = 4; end
      5: begin l = 7; k = 8; eta = 2; end
      default: legal = 0;
    endcase
  endfunction

  function automatic int ref_coeff(input int x, input int eta);
    return (x <= eta) ? (eta - x) : (Q - (x - eta));
  endfunction

  // Monitor: pops the scoreboard on every write, tracks start/done pulses
  wr_t e;
  always @(negedge clk) begin
    if (o_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(o_wr_addr), e.addr);
        chk("wr_data", int'(o_wr_data), e.data);
      end
    end
    if (o_smp_start) begin
      start_cnt++;
      chk("smp_row", int'(o_smp_row), exp_row);
      chk("smp_level", int'(o_smp_level), exp_level);
      exp_row++;
    end
    if (o_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_smp_start"}, o_smp_start, 0);
    chk({tag, "_smp_level"}, int'(o_smp_level), 0);
    chk({tag, "_smp_row"}, int'(o_smp_row), 0);
    chk({tag, "_wr_en"}, o_wr_en, 0);
    chk({tag, "_wr_addr"}, int'(o_wr_addr), 0);
    chk({tag, "_wr_data"}, int'(o_wr_data), 0);
  endtask

  task automatic run_level(input int lvl, input bit extra, input int abort_poly, output bit aborted);
    int l, k, eta, n_poly, x;
    bit legal, got;
    aborted = 0;
    lvl_params(lvl, l, k, eta, legal);
    n_poly = l + k;
    wr_cnt = 0; start_cnt = 0; done_cnt = 0; exp_row = 0; exp_level = lvl;
    i_security_level = 3'(lvl);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_security_level = 3'($urandom_range(0, 7));
    for (int p = 0; p < n_poly; p++) begin
      got = 0;
      for (int t = 0; t < 40; t++) begin
        if (o_smp_start) begin got = 1; break; end
        tick();
      end
      if (!got) begin chk("start_timeout", 0, 1); return; end
      // stale done from the previous row stays high one more cycle
      tick();
      i_smp_done = 1'b0;
      for (int c = 0; c < 256; c++) begin
        if (p == abort_poly && c == 100) begin aborted = 1; return; end
        x = $urandom_range(0, 2 * eta);
        if (lvl == 3 && c == 0) x = 0;
        if (lvl == 3 && c == 1) x = 2 * eta;
        i_smp_coeff_valid = 1'b1;
        i_smp_coeff_data = 4'(x);
        exp_q.push_back('{addr: p * 256 + c, data: ref_coeff(x, eta)});
        if (p == 1 && c == 5) begin
          i_start = 1'b1;
          i_security_level = 3'($urandom_range(0, 7));
        end
        tick();
        i_start = 1'b0;
        i_smp_coeff_valid = 1'b0;
        tick();
        tick();
      end
      if (extra && p == n_poly - 1) begin
        i_smp_coeff_valid = 1'b1;
        i_smp_coeff_data = 4'($urandom_range(0, 2 * eta));
        tick();
        i_smp_coeff_valid = 1'b0;
        tick();
      end
      i_smp_done = 1'b1;
    end
    got = 0;
    for (int t = 0; t < 20; t++) begin
      if (o_done) begin got = 1; break; end
      tick();
    end
    if (!got) begin chk("done_timeout", 0, 1); return; end
    chk("err_at_done", o_err, extra ? 1 : 0);
    chk("busy_at_done", o_busy, 0);
    tick();
    chk("done_pulse_width", o_done, 0);
    chk("done_cnt", done_cnt, 1);
    chk("start_cnt", start_cnt, n_poly);
    chk("wr_cnt", wr_cnt, 256 * n_poly);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit ab;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("idle_busy", o_busy, 0);

    run_level(2, 0, -1, ab);
    run_level(3, 0, -1, ab);
    run_level(5, 0, -1, ab);

    // illegal level 4
    start_cnt = 0;
    i_security_level = 3'd4;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("illegal_done", o_done, 1);
    chk("illegal_err", o_err, 1);
    chk("illegal_busy", o_busy, 0);
    chk("illegal_smp_start", o_smp_start, 0);
    tick();
    chk("illegal_done_low", o_done, 0);
    chk("illegal_start_cnt", start_cnt, 0);

    // extra valid after the 256th coefficient of the last row
    run_level(2, 1, -1, ab);

    // reset mid-COLLECT on poly 3
    run_level(2, 0, 3, ab);
    chk("abort_reached", ab, 1);
    chk("abort_busy_before", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    repeat (3) tick();
    chk("abort_scoreboard", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b1;
    tick();
    run_level(3, 0, -1, ab);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
